scb_initiator: RTL and testbench

Bus initiator for the Minx16 SCB scratchpad interface. It converts single core-side load/store requests (byte or 16-bit word, any byte address) into SCB cycles: byte-lane strobes, chip-enable, and rd/wr qualifiers. It waits on `scb_rdy_i`, captures read data one cycle after acceptance, and returns one response per request. Misaligned words are split into two byte cycles. Stalled cycles are aborted by a timeout.

---
 rtl/scb_initiator.sv | 193 +++++++++++++++++++
 tb/tb_scb_initiator.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scb_initiator.sv
// Minx16 SCB scratchpad initiator: turns single byte/word load/store requests
// into SCB cycles, splitting misaligned words into two byte cycles.
module scb_initiator #(
    parameter int unsigned A       = 11,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [A-1:0] req_addr_i,
    input  logic         req_wr_i,
    input  logic         req_size_i,
    input  logic [15:0]  req_data_i,
    output logic         rsp_valid_o,
    output logic [15:0]  rsp_data_o,
    output logic         rsp_err_o,
    output logic [A-1:0] scb_Addr_o,
    output logic [15:0]  scb_Data_o,
    input  logic [15:0]  scb_Data_i,
    output logic [1:0]   scb_stb_o,
    output logic         scb_ce_o,
    output logic         scb_rd_o,
    output logic         scb_wr_o,
    input  logic         scb_rdy_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_CAP,
        S_RSP
    } state_e;

    state_e        state_q, state_d;
    logic          phase_q, phase_d;
    logic [A-1:0]  addr_q, addr_d;
    logic          wr_q, wr_d;
    logic          size_q, size_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   tcnt_q, tcnt_d;

    logic          split;
    logic          timeout_hit;

    assign split = size_q & addr_q[0];

    // The stall that would bring the count to TIMEOUT ends the cycle.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && !scb_rdy_i && (tcnt_q == 32'(TIMEOUT - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = S_REQ;
                    addr_d  = req_addr_i;
                    wr_d    = req_wr_i;
                    size_d  = req_size_i;
                    wdata_d = req_data_i;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    phase_d = 1'b0;
                    tcnt_d  = '0;
                end
            end
            S_REQ: begin
                if (scb_rdy_i) begin
                    tcnt_d = '0;
                    if (!wr_q) begin
                        state_d = S_CAP;
                    end else if (split && !phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        state_d = S_RSP;
                    end
                end else if (timeout_hit) begin
                    state_d = S_RSP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
            S_CAP: begin
                // Registered SRAM data is valid in this cycle; merge the addressed lane(s).
                if (!size_q) begin
                    rdata_d = {8'h00, addr_q[0] ? scb_Data_i[15:8] : scb_Data_i[7:0]};
                end else if (!split) begin
                    rdata_d = scb_Data_i;
                end else if (!phase_q) begin
                    rdata_d[7:0] = scb_Data_i[15:8];
                end else begin
                    rdata_d[15:8] = scb_Data_i[7:0];
                end
                if (split && !phase_q) begin
                    phase_d = 1'b1;
                    tcnt_d  = '0;
                    state_d = S_REQ;
                end else begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == S_IDLE) && !rst_i;
        rsp_valid_o = 1'b0;
        rsp_data_o  = '0;
        rsp_err_o   = 1'b0;
        scb_Addr_o  = '0;
        scb_Data_o  = '0;
        scb_stb_o   = '0;
        scb_ce_o    = 1'b0;
        scb_rd_o    = 1'b0;
        scb_wr_o    = 1'b0;
        case (state_q)
            S_REQ: begin
                scb_ce_o   = 1'b1;
                scb_rd_o   = !wr_q;
                scb_wr_o   = wr_q;
                scb_Addr_o = addr_q + {{(A-1){1'b0}}, phase_q};
                if (!size_q) begin
                    scb_stb_o  = addr_q[0] ? 2'b10 : 2'b01;
                    scb_Data_o = {wdata_q[7:0], wdata_q[7:0]};
                end else if (!split) begin
                    scb_stb_o  = 2'b11;
                    scb_Data_o = wdata_q;
                end else if (!phase_q) begin
                    scb_stb_o  = 2'b10;
                    scb_Data_o = {wdata_q[7:0], 8'h00};
                end else begin
                    scb_stb_o  = 2'b01;
                    scb_Data_o = {8'h00, wdata_q[15:8]};
                end
                if (!wr_q) begin
                    scb_Data_o = '0;
                end
            end
            S_RSP: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = rdata_q;
                rsp_err_o   = err_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_scb_initiator.sv
// Self-checking bench for scb_initiator: registered-output SRAM responder,
// byte-level reference memory, and queues of expected bus cycles and responses.
module tb_scb_initiator;

    localparam int unsigned A  = 11;
    localparam int unsigned TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [A-1:0] req_addr;
    logic         req_wr;
    logic         req_size;
    logic [15:0]  req_data;
    logic         rsp_valid;
    logic [15:0]  rsp_data;
    logic         rsp_err;
    logic [A-1:0] scb_addr;
    logic [15:0]  scb_wdata;
    logic [15:0]  scb_rdata;
    logic [1:0]   scb_stb;
    logic         scb_ce;
    logic         scb_rd;
    logic         scb_wr;
    logic         scb_rdy;

    scb_initiator #(.A(A), .TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_wr_i    (req_wr),
        .req_size_i  (req_size),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .scb_Addr_o  (scb_addr),
        .scb_Data_o  (scb_wdata),
        .scb_Data_i  (scb_rdata),
        .scb_stb_o   (scb_stb),
        .scb_ce_o    (scb_ce),
        .scb_rd_o    (scb_rd),
        .scb_wr_o    (scb_wr),
        .scb_rdy_i   (scb_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [A-1:0] addr;
        logic [1:0]   stb;
        logic         wr;
        logic [15:0]  data;
    } bus_t;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   waiting = 1'b0;

    logic [7:0]  ref_mem [0:(1<<A)-1];
    logic [15:0] sram    [0:(1<<(A-1))-1];
    logic [15:0] sram_q;

    bus_t        mon_e;
    logic [15:0] mon_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM responder: read data appears one cycle after the accepted read, junk otherwise.
    assign scb_rdata = sram_q;
    always @(posedge clk) begin
        sram_q <= 16'($urandom);
        if (scb_ce && scb_rdy) begin
            if (scb_wr) begin
                if (scb_stb[0]) sram[scb_addr[A-1:1]][7:0]  <= scb_wdata[7:0];
                if (scb_stb[1]) sram[scb_addr[A-1:1]][15:8] <= scb_wdata[15:8];
            end else begin
                sram_q <= sram[scb_addr[A-1:1]];
            end
        end
    end

    always @(negedge clk) begin
        if (scb_ce) begin
            check("rdwr_excl", 32'(scb_rd ^ scb_wr), 32'd1);
            if (bus_q.size() == 0) begin
                check("bus_unexp", 32'd1, 32'd0);
            end else begin
                mon_e = bus_q[0];
                mon_m = {{8{mon_e.stb[1]}}, {8{mon_e.stb[0]}}};
                check("bus_addr", 32'(scb_addr), 32'(mon_e.addr));
                check("bus_stb", 32'(scb_stb), 32'(mon_e.stb));
                check("bus_wr", 32'(scb_wr), 32'(mon_e.wr));
                if (mon_e.wr) check("bus_data", 32'(scb_wdata & mon_m), 32'(mon_e.data & mon_m));
                if (scb_rdy) void'(bus_q.pop_front());
            end
        end
        if (rsp_valid && !waiting) check("spurious_rsp", 32'd1, 32'd0);
    end

    // stall > 0: rdy low for that many REQ cycles; stall < 0: rdy never returns (timeout).
    task automatic do_req(input logic [A-1:0] a, input logic wr, input logic sz,
                          input logic [15:0] d, input int stall);
        logic         split = sz & a[0];
        logic [A-1:0] a1 = a + 11'd1;
        rsp_t         r;
        int           c0 = 0;
        bit           got = 1'b0;
        if (!sz) begin
            bus_q.push_back('{a, a[0] ? 2'b10 : 2'b01, wr, {d[7:0], d[7:0]}});
        end else if (!split) begin
            bus_q.push_back('{a, 2'b11, wr, d});
        end else begin
            bus_q.push_back('{a, 2'b10, wr, {d[7:0], 8'h00}});
            bus_q.push_back('{a1, 2'b01, wr, {8'h00, d[15:8]}});
        end
        if (stall < 0) begin
            r.data = 16'h0000;
            r.err  = 1'b1;
            r.lat  = TO + 1;
        end else begin
            r.err = 1'b0;
            if (wr) begin
                ref_mem[a] = d[7:0];
                if (sz) ref_mem[a1] = d[15:8];
                r.data = 16'h0000;
                r.lat  = (split ? 3 : 2) + stall;
            end else begin
                r.data = sz ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
                r.lat  = (split ? 5 : 3) + stall;
            end
        end
        rsp_q.push_back(r);
        if (stall != 0) scb_rdy = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_wr    = wr;
        req_size  = sz;
        req_data  = d;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready) begin
                c0  = cyc;
                got = 1'b1;
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (!got) begin
            check("accept_to", 32'd0, 32'd1);
            rsp_q.delete();
            bus_q.delete();
            scb_rdy = 1'b1;
            return;
        end
        waiting = 1'b1;
        got = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                r = rsp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(r.data));
                check("rsp_err", 32'(rsp_err), 32'(r.err));
                check("rsp_lat", 32'(cyc - c0), 32'(r.lat));
                got = 1'b1;
            end else if (k == stall) begin
                @(posedge clk);
                #1 scb_rdy = 1'b1;
            end
        end
        if (!got) begin
            check("rsp_to", 32'd0, 32'd1);
            rsp_q.delete();
        end else begin
            @(negedge clk);
            check("rsp_pulse", 32'(rsp_valid), 32'd0);
            check("ready_back", 32'(req_ready), 32'd1);
        end
        waiting = 1'b0;
        scb_rdy = 1'b1;
        if (stall >= 0) check("bus_done", 32'(bus_q.size()), 32'd0);
        bus_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << A); i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < (1 << (A-1)); i++) sram[i] = 16'h0000;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wr    = 1'b0;
        req_size  = 1'b0;
        req_data  = '0;
        scb_rdy   = 1'b1;

        @(posedge clk);
        @(negedge clk);
        check("rst_ce", 32'(scb_ce), 32'd0);
        check("rst_rsp", 32'(rsp_valid), 32'd0);
        check("rst_stb", 32'(scb_stb), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        do_req(11'h040, 1'b1, 1'b1, 16'hBEEF, 0);
        do_req(11'h040, 1'b0, 1'b1, 16'h0000, 0);
        do_req(11'h041, 1'b0, 1'b0, 16'h0000, 0);
        do_req(11'h040, 1'b0, 1'b0, 16'h0000, 0);
        do_req(11'h043, 1'b1, 1'b1, 16'h1234, 0);
        do_req(11'h043, 1'b0, 1'b1, 16'h0000, 0);
        do_req(11'h045, 1'b1, 1'b0, 16'h77A5, 0);
        do_req(11'h046, 1'b1, 1'b0, 16'h113C, 0);
        do_req(11'h044, 1'b0, 1'b1, 16'h0000, 0);
        do_req(11'h046, 1'b0, 1'b0, 16'h0000, 0);
        do_req(11'h7FF, 1'b1, 1'b1, 16'hCAFE, 0);
        do_req(11'h000, 1'b0, 1'b0, 16'h0000, 0);
        do_req(11'h7FF, 1'b0, 1'b1, 16'h0000, 0);
        do_req(11'h050, 1'b1, 1'b1, 16'h5AA5, 3);
        do_req(11'h050, 1'b0, 1'b1, 16'h0000, 3);
        do_req(11'h043, 1'b0, 1'b1, 16'h0000, 2);
        do_req(11'h040, 1'b0, 1'b1, 16'h0000, -1);
        do_req(11'h040, 1'b0, 1'b1, 16'h0000, 0);

        // Reset during CAP of phase 0 of a split read.
        bus_q.push_back('{11'h043, 2'b10, 1'b0, 16'h0000});
        req_valid = 1'b1;
        req_addr  = 11'h043;
        req_wr    = 1'b0;
        req_size  = 1'b1;
        @(negedge clk);
        check("rr_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rr_cap_ce", 32'(scb_ce), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rr_ce_after", 32'(scb_ce), 32'd0);
        check("rr_ready_after", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("rr_bus_done", 32'(bus_q.size()), 32'd0);
        bus_q.delete();
        @(posedge clk);
        #1;
        do_req(11'h043, 1'b0, 1'b1, 16'h0000, 0);

        for (int i = 0; i < 10; i++) begin
            logic [A-1:0] ra;
            ra = 11'h060 + 11'($urandom_range(0, 15));
            do_req(ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x1 expected 0x0");
        $fatal(1, "bench time limit expired");
    end

endmodule
